// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'b000,
        SHL   = 3'b001,
        SHR   = 3'b010,
        ROL   = 3'b011,
        ROR   = 3'b100,
        LOAD  = 3'b101,
        CLEAR = 3'b110,
        RSVD  = 3'b111
    } usr_mode_e;

    localparam int USR_DEFAULT_WIDTH = 8;

    // Frame counter width; never below one bit so a 2-bit register still counts.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic is_shift_op(input usr_mode_e op);
        return (op == SHL) || (op == SHR) || (op == ROL) || (op == ROR);
    endfunction

    function automatic logic is_reset_op(input usr_mode_e op);
        return (op == LOAD) || (op == CLEAR);
    endfunction

endpackage

// File: rtl/usr_frame_counter.sv
// Counts shift/rotate ops modulo WIDTH and flags the op that closes a frame.
module usr_frame_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    // Terminal count is WIDTH-1, not the natural rollover of the counter.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_nxt;

    assign wrap = inc && (cnt == CNT_MAX);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (wrap) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with hold/shift/rotate/load/clear and frame capture.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pload,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done,
    output logic [WIDTH-1:0] frame_word
);

    usr_mode_e        op;
    logic [WIDTH-1:0] q_nxt;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             wrap;

    assign op      = usr_mode_e'(mode);
    assign cnt_inc = is_shift_op(op);
    assign cnt_clr = is_reset_op(op);
    assign sout_l  = q[WIDTH-1];
    assign sout_r  = q[0];

    always_comb begin
        q_nxt = q;
        case (op)
            SHL:     q_nxt = {q[WIDTH-2:0], sin_l};
            SHR:     q_nxt = {sin_r, q[WIDTH-1:1]};
            ROL:     q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            ROR:     q_nxt = {q[0], q[WIDTH-1:1]};
            LOAD:    q_nxt = pload;
            CLEAR:   q_nxt = '0;
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    usr_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (shift_cnt),
        .wrap  (wrap)
    );

    // The captured word is the post-shift value, so take it from q_nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_word <= '0;
        end else begin
            frame_done <= wrap;
            if (wrap) begin
                frame_word <= q_nxt;
            end
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed, table-driven bench for universal_shift_reg at WIDTH=8 and WIDTH=5.
module tb_universal_shift_reg;
    import usr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n8, rst_n5;
    logic [2:0] mode8, mode5;
    logic       sin_l8, sin_r8, sin_l5, sin_r5;
    logic [7:0] pload8, q8, fw8;
    logic [4:0] pload5, q5, fw5;
    logic       sout_l8, sout_r8, sout_l5, sout_r5;
    logic [2:0] cnt8, cnt5;
    logic       done8, done5;

    universal_shift_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .mode(mode8), .sin_l(sin_l8), .sin_r(sin_r8),
        .pload(pload8), .q(q8), .sout_l(sout_l8), .sout_r(sout_r8),
        .shift_cnt(cnt8), .frame_done(done8), .frame_word(fw8)
    );

    universal_shift_reg #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n5), .mode(mode5), .sin_l(sin_l5), .sin_r(sin_r5),
        .pload(pload5), .q(q5), .sout_l(sout_l5), .sout_r(sout_r5),
        .shift_cnt(cnt5), .frame_done(done5), .frame_word(fw5)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] mode;
        logic       sl;
        logic       sr;
        logic [7:0] pl;
        logic [7:0] q;
        logic [2:0] cnt;
        logic       done;
        logic [7:0] fw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] m, input logic sl, input logic sr,
                                input logic [7:0] pl, input logic [7:0] eq,
                                input logic [2:0] ec, input logic ed, input logic [7:0] ef);
        vec_t v;
        v.mode = m; v.sl = sl; v.sr = sr; v.pl = pl;
        v.q = eq; v.cnt = ec; v.done = ed; v.fw = ef;
        return v;
    endfunction

    initial begin
        rst_n8 = 1'b0; rst_n5 = 1'b0;
        mode8 = SHL; mode5 = SHL;
        sin_l8 = 1'b0; sin_r8 = 1'b0; sin_l5 = 1'b0; sin_r5 = 1'b0;
        pload8 = '0; pload5 = '0;

        // Reset held while SHL is requested with a toggling serial input.
        for (int i = 0; i < 4; i++) begin
            sin_l8 = ~sin_l8;
            sin_l5 = ~sin_l5;
            @(posedge clk); #1;
            chk($sformatf("rst%0d q", i), 32'(q8), 32'h00);
            chk($sformatf("rst%0d cnt", i), 32'(cnt8), 32'h0);
            chk($sformatf("rst%0d done", i), 32'(done8), 32'h0);
            chk($sformatf("rst%0d fw", i), 32'(fw8), 32'h00);
        end
        rst_n8 = 1'b1;
        rst_n5 = 1'b1;
        mode5 = HOLD;

        // SIPO 1,0,1,1,0,0,1,0
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h01, 3'd1, 0, 8'h00));
        vecs.push_back(mk(SHL, 0, 0, 8'h00, 8'h02, 3'd2, 0, 8'h00));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h05, 3'd3, 0, 8'h00));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h0B, 3'd4, 0, 8'h00));
        vecs.push_back(mk(SHL, 0, 0, 8'h00, 8'h16, 3'd5, 0, 8'h00));
        vecs.push_back(mk(SHL, 0, 0, 8'h00, 8'h2C, 3'd6, 0, 8'h00));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h59, 3'd7, 0, 8'h00));
        vecs.push_back(mk(SHL, 0, 0, 8'h00, 8'hB2, 3'd0, 1, 8'hB2));
        // PISO / rotate
        vecs.push_back(mk(LOAD, 0, 0, 8'h81, 8'h81, 3'd0, 0, 8'hB2));
        vecs.push_back(mk(ROR, 0, 0, 8'h00, 8'hC0, 3'd1, 0, 8'hB2));
        vecs.push_back(mk(ROR, 0, 0, 8'h00, 8'h60, 3'd2, 0, 8'hB2));
        vecs.push_back(mk(ROR, 0, 0, 8'h00, 8'h30, 3'd3, 0, 8'hB2));
        vecs.push_back(mk(ROL, 0, 0, 8'h00, 8'h60, 3'd4, 0, 8'hB2));
        vecs.push_back(mk(ROL, 0, 0, 8'h00, 8'hC0, 3'd5, 0, 8'hB2));
        vecs.push_back(mk(ROL, 0, 0, 8'h00, 8'h81, 3'd6, 0, 8'hB2));
        // Counter clear by LOAD / CLEAR
        vecs.push_back(mk(CLEAR, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'hB2));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h01, 3'd1, 0, 8'hB2));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h03, 3'd2, 0, 8'hB2));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h07, 3'd3, 0, 8'hB2));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h0F, 3'd4, 0, 8'hB2));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h1F, 3'd5, 0, 8'hB2));
        vecs.push_back(mk(LOAD, 0, 0, 8'hFF, 8'hFF, 3'd0, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h7F, 3'd1, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h3F, 3'd2, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h1F, 3'd3, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h0F, 3'd4, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h07, 3'd5, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h03, 3'd6, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h01, 3'd7, 0, 8'hB2));
        vecs.push_back(mk(SHR, 0, 0, 8'h00, 8'h00, 3'd0, 1, 8'h00));
        // LOAD right after a boundary, then reserved and HOLD
        vecs.push_back(mk(LOAD, 0, 0, 8'h5A, 8'h5A, 3'd0, 0, 8'h00));
        vecs.push_back(mk(RSVD, 1, 1, 8'hFF, 8'h5A, 3'd0, 0, 8'h00));
        vecs.push_back(mk(RSVD, 0, 1, 8'h00, 8'h5A, 3'd0, 0, 8'h00));
        vecs.push_back(mk(RSVD, 1, 0, 8'hFF, 8'h5A, 3'd0, 0, 8'h00));
        vecs.push_back(mk(RSVD, 0, 0, 8'h00, 8'h5A, 3'd0, 0, 8'h00));
        vecs.push_back(mk(HOLD, 1, 1, 8'hFF, 8'h5A, 3'd0, 0, 8'h00));
        // Direction change mid-frame
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'hB5, 3'd1, 0, 8'h00));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'h6B, 3'd2, 0, 8'h00));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'hD7, 3'd3, 0, 8'h00));
        vecs.push_back(mk(SHL, 1, 0, 8'h00, 8'hAF, 3'd4, 0, 8'h00));
        vecs.push_back(mk(SHR, 0, 1, 8'h00, 8'hD7, 3'd5, 0, 8'h00));
        vecs.push_back(mk(SHR, 0, 1, 8'h00, 8'hEB, 3'd6, 0, 8'h00));
        vecs.push_back(mk(SHR, 0, 1, 8'h00, 8'hF5, 3'd7, 0, 8'h00));
        vecs.push_back(mk(SHR, 0, 1, 8'h00, 8'hFA, 3'd0, 1, 8'hFA));
        vecs.push_back(mk(HOLD, 0, 0, 8'h00, 8'hFA, 3'd0, 0, 8'hFA));

        for (int i = 0; i < vecs.size(); i++) begin
            mode8  = vecs[i].mode;
            sin_l8 = vecs[i].sl;
            sin_r8 = vecs[i].sr;
            pload8 = vecs[i].pl;
            @(posedge clk); #1;
            chk($sformatf("v%0d q", i), 32'(q8), 32'(vecs[i].q));
            chk($sformatf("v%0d cnt", i), 32'(cnt8), 32'(vecs[i].cnt));
            chk($sformatf("v%0d done", i), 32'(done8), 32'(vecs[i].done));
            chk($sformatf("v%0d fw", i), 32'(fw8), 32'(vecs[i].fw));
            chk($sformatf("v%0d sout_l", i), 32'(sout_l8), 32'(vecs[i].q[7]));
            chk($sformatf("v%0d sout_r", i), 32'(sout_r8), 32'(vecs[i].q[0]));
        end
        mode8 = HOLD;

        // WIDTH=5: twelve SHL of ones, boundaries at shifts 5 and 10.
        mode5  = SHL;
        sin_l5 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            logic [4:0] eq;
            eq = (i >= 5) ? 5'h1F : 5'((1 << i) - 1);
            @(posedge clk); #1;
            chk($sformatf("w5 s%0d q", i), 32'(q5), 32'(eq));
            chk($sformatf("w5 s%0d cnt", i), 32'(cnt5), 32'(i % 5));
            chk($sformatf("w5 s%0d done", i), 32'(done5), 32'((i % 5) == 0));
            chk($sformatf("w5 s%0d fw", i), 32'(fw5), (i >= 5) ? 32'h1F : 32'h0);
        end
        chk("w5 end cnt", 32'(cnt5), 32'd2);

        // Mid-cycle reset clears state without a clock edge.
        mode5 = HOLD;
        #2;
        rst_n5 = 1'b0;
        #1;
        chk("w5 async q", 32'(q5), 32'h0);
        chk("w5 async cnt", 32'(cnt5), 32'h0);
        chk("w5 async fw", 32'(fw5), 32'h0);
        #1;
        rst_n5 = 1'b1;

        // First post-reset frame needs all five shifts.
        mode5  = SHL;
        sin_l5 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("w5 post s%0d cnt", i), 32'(cnt5), 32'(i % 5));
            chk($sformatf("w5 post s%0d done", i), 32'(done5), 32'(i == 5));
        end
        mode5 = HOLD;
        @(posedge clk); #1;
        chk("w5 post done drop", 32'(done5), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
